// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit computer: opcodes, microstep encoding and
// control-word bit positions used by the control unit and its decoder.
package cpu_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic [DATA_W-1:0] OP_NOP  = 8'h00;
   localparam logic [DATA_W-1:0] OP_LDA  = 8'h01;
   localparam logic [DATA_W-1:0] OP_LDB  = 8'h02;
   localparam logic [DATA_W-1:0] OP_ADDA = 8'h03;
   localparam logic [DATA_W-1:0] OP_ADDB = 8'h04;
   localparam logic [DATA_W-1:0] OP_ADDO = 8'h05;
   localparam logic [DATA_W-1:0] OP_SUBA = 8'h06;
   localparam logic [DATA_W-1:0] OP_SUBB = 8'h07;
   localparam logic [DATA_W-1:0] OP_SUBO = 8'h08;
   localparam logic [DATA_W-1:0] OP_CMP  = 8'h09;
   localparam logic [DATA_W-1:0] OP_JMP  = 8'h0A;
   localparam logic [DATA_W-1:0] OP_JEQ  = 8'h0B;
   localparam logic [DATA_W-1:0] OP_JGT  = 8'h0C;
   localparam logic [DATA_W-1:0] OP_JLT  = 8'h0D;
   localparam logic [DATA_W-1:0] OP_HLT  = 8'h0F;

   // STEP_HALT is what `step` reads while the machine is parked.
   typedef enum logic [2:0] {
      STEP_T0   = 3'd0,
      STEP_T1   = 3'd1,
      STEP_T2   = 3'd2,
      STEP_T3   = 3'd3,
      STEP_T4   = 3'd4,
      STEP_HALT = 3'd5
   } step_e;

   localparam int unsigned CW_A_IN     = 0;
   localparam int unsigned CW_B_IN     = 1;
   localparam int unsigned CW_C_OUT    = 2;
   localparam int unsigned CW_FLAGS_IN = 3;
   localparam int unsigned CW_PC_OUT   = 4;
   localparam int unsigned CW_PC_INC   = 5;
   localparam int unsigned CW_PC_LOAD  = 6;
   localparam int unsigned CW_MAR_IN   = 7;
   localparam int unsigned CW_RAM_OUT  = 8;
   localparam int unsigned CW_OUT_IN   = 9;
   localparam int unsigned CW_W        = 10;

   typedef logic [CW_W-1:0] ctrl_t;

   function automatic logic has_operand(input logic [DATA_W-1:0] op);
      return op inside {OP_LDA, OP_LDB, OP_JMP, OP_JEQ, OP_JGT, OP_JLT};
   endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational microcode ROM: maps microstep, opcode, ALU flags and halt
// state onto the control word. No state lives here.
module control_decode
   import cpu_pkg::*;
(
   input  step_e              step_i,
   input  logic [DATA_W-1:0]  opcode_i,
   input  logic               equal_i,
   input  logic               greater_i,
   input  logic               lesser_i,
   input  logic               halted_i,
   output ctrl_t              ctrl_o
);

   logic jump_taken;

   always_comb begin
      jump_taken = 1'b0;
      case (opcode_i)
         OP_JMP:  jump_taken = 1'b1;
         OP_JEQ:  jump_taken = equal_i;
         OP_JGT:  jump_taken = greater_i;
         OP_JLT:  jump_taken = lesser_i;
         default: jump_taken = 1'b0;
      endcase
   end

   always_comb begin
      ctrl_o = '0;
      if (!halted_i) begin
         case (step_i)
            STEP_T0: begin
               ctrl_o[CW_PC_OUT] = 1'b1;
               ctrl_o[CW_MAR_IN] = 1'b1;
            end
            STEP_T1: begin
               ctrl_o[CW_RAM_OUT] = 1'b1;
               ctrl_o[CW_PC_INC]  = 1'b1;
            end
            STEP_T2: begin
               case (opcode_i)
                  OP_LDA, OP_LDB, OP_JMP, OP_JEQ, OP_JGT, OP_JLT: begin
                     ctrl_o[CW_PC_OUT] = 1'b1;
                     ctrl_o[CW_MAR_IN] = 1'b1;
                  end
                  OP_ADDA, OP_SUBA: begin
                     ctrl_o[CW_C_OUT] = 1'b1;
                     ctrl_o[CW_A_IN]  = 1'b1;
                  end
                  OP_ADDB, OP_SUBB: begin
                     ctrl_o[CW_C_OUT] = 1'b1;
                     ctrl_o[CW_B_IN]  = 1'b1;
                  end
                  OP_ADDO, OP_SUBO: begin
                     ctrl_o[CW_C_OUT]  = 1'b1;
                     ctrl_o[CW_OUT_IN] = 1'b1;
                  end
                  OP_CMP:  ctrl_o[CW_FLAGS_IN] = 1'b1;
                  default: ;
               endcase
            end
            STEP_T3: begin
               case (opcode_i)
                  OP_LDA: begin
                     ctrl_o[CW_RAM_OUT] = 1'b1;
                     ctrl_o[CW_A_IN]    = 1'b1;
                     ctrl_o[CW_PC_INC]  = 1'b1;
                  end
                  OP_LDB: begin
                     ctrl_o[CW_RAM_OUT] = 1'b1;
                     ctrl_o[CW_B_IN]    = 1'b1;
                     ctrl_o[CW_PC_INC]  = 1'b1;
                  end
                  // Untaken conditional jumps just step the PC past the operand.
                  OP_JMP, OP_JEQ, OP_JGT, OP_JLT: begin
                     if (jump_taken) begin
                        ctrl_o[CW_RAM_OUT] = 1'b1;
                        ctrl_o[CW_PC_LOAD] = 1'b1;
                     end else begin
                        ctrl_o[CW_PC_INC]  = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/control_unit.sv
// Instruction register and microstep sequencer. Holds IR, step and halt
// state; control outputs are a Moore decode forced low while reset is held.
module control_unit
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [DATA_W-1:0]  bus,
   input  logic               equal,
   input  logic               greater,
   input  logic               lesser,
   output logic [DATA_W-1:0]  operation,
   output logic               a_enable_in,
   output logic               b_enable_in,
   output logic               c_enable_out,
   output logic               flags_enable_in,
   output logic               pc_enable_out,
   output logic               pc_inc,
   output logic               pc_load,
   output logic               mar_enable_in,
   output logic               ram_enable_out,
   output logic               out_enable_in,
   output logic [2:0]         step,
   output logic               halted
);

   step_e              step_q, step_d;
   logic [DATA_W-1:0]  ir_q, ir_d;
   logic               halted_q, halted_d;
   ctrl_t              ctrl_dec;
   ctrl_t              ctrl;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_q   <= STEP_T0;
         ir_q     <= '0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         ir_q     <= ir_d;
         halted_q <= halted_d;
      end
   end

   // Halt is flagged as HLT is latched so `halted` is already high during its T2.
   always_comb begin
      step_d   = step_q;
      ir_d     = ir_q;
      halted_d = halted_q;
      case (step_q)
         STEP_T0: step_d = STEP_T1;
         STEP_T1: begin
            step_d   = STEP_T2;
            ir_d     = bus;
            halted_d = (bus == OP_HLT);
         end
         STEP_T2: begin
            if (halted_q)
               step_d = STEP_HALT;
            else if (has_operand(ir_q))
               step_d = STEP_T3;
            else
               step_d = STEP_T0;
         end
         STEP_T3:   step_d = STEP_T0;
         STEP_T4:   step_d = STEP_T0;
         STEP_HALT: step_d = STEP_HALT;
         default:   step_d = STEP_T0;
      endcase
   end

   control_decode u_decode (
      .step_i    (step_q),
      .opcode_i  (ir_q),
      .equal_i   (equal),
      .greater_i (greater),
      .lesser_i  (lesser),
      .halted_i  (halted_q),
      .ctrl_o    (ctrl_dec)
   );

   always_comb begin
      ctrl = reset ? ctrl_dec : '0;
   end

   assign a_enable_in     = ctrl[CW_A_IN];
   assign b_enable_in     = ctrl[CW_B_IN];
   assign c_enable_out    = ctrl[CW_C_OUT];
   assign flags_enable_in = ctrl[CW_FLAGS_IN];
   assign pc_enable_out   = ctrl[CW_PC_OUT];
   assign pc_inc          = ctrl[CW_PC_INC];
   assign pc_load         = ctrl[CW_PC_LOAD];
   assign mar_enable_in   = ctrl[CW_MAR_IN];
   assign ram_enable_out  = ctrl[CW_RAM_OUT];
   assign out_enable_in   = ctrl[CW_OUT_IN];

   assign operation = ir_q;
   assign step      = step_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level reference model,
// randomized opcode/flag stimulus and directed reset/jump/halt scenarios.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] bus;
   logic       equal, greater, lesser;
   logic [7:0] operation;
   logic       a_enable_in, b_enable_in, c_enable_out, flags_enable_in;
   logic       pc_enable_out, pc_inc, pc_load;
   logic       mar_enable_in, ram_enable_out, out_enable_in;
   logic [2:0] step;
   logic       halted;

   always #5 clk = ~clk;

   control_unit dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .equal           (equal),
      .greater         (greater),
      .lesser          (lesser),
      .operation       (operation),
      .a_enable_in     (a_enable_in),
      .b_enable_in     (b_enable_in),
      .c_enable_out    (c_enable_out),
      .flags_enable_in (flags_enable_in),
      .pc_enable_out   (pc_enable_out),
      .pc_inc          (pc_inc),
      .pc_load         (pc_load),
      .mar_enable_in   (mar_enable_in),
      .ram_enable_out  (ram_enable_out),
      .out_enable_in   (out_enable_in),
      .step            (step),
      .halted          (halted)
   );

   // Bench-side naming of the ten control lines, independent of the RTL packing.
   localparam logic [9:0] A   = 10'h200;
   localparam logic [9:0] B   = 10'h100;
   localparam logic [9:0] C   = 10'h080;
   localparam logic [9:0] FL  = 10'h040;
   localparam logic [9:0] PCO = 10'h020;
   localparam logic [9:0] INC = 10'h010;
   localparam logic [9:0] LD  = 10'h008;
   localparam logic [9:0] MAR = 10'h004;
   localparam logic [9:0] RAM = 10'h002;
   localparam logic [9:0] OUT = 10'h001;

   logic [9:0] act;
   assign act = {a_enable_in, b_enable_in, c_enable_out, flags_enable_in, pc_enable_out,
                 pc_inc, pc_load, mar_enable_in, ram_enable_out, out_enable_in};

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic        chk_en = 1'b0;
   logic [9:0]  exp_ctrl;
   logic [7:0]  exp_op;
   logic [2:0]  exp_step;
   logic        exp_halt;
   logic [7:0]  m_ir;
   logic        m_halt;
   logic        t0_done = 1'b0;

   task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
      end
   endtask

   function automatic logic long_op(input logic [7:0] op);
      return (op == 8'h01) || (op == 8'h02) || (op >= 8'h0A && op <= 8'h0D);
   endfunction

   function automatic logic [9:0] dest_of(input int unsigned k);
      case (k)
         0:       return A;
         1:       return B;
         default: return OUT;
      endcase
   endfunction

   function automatic logic [9:0] t2_ctrl(input logic [7:0] op);
      if (long_op(op)) return PCO | MAR;
      if (op >= 8'h03 && op <= 8'h08) return C | dest_of((int'(op) - 3) % 3);
      if (op == 8'h09) return FL;
      return '0;
   endfunction

   function automatic logic [9:0] t3_ctrl(input logic [7:0] op, input logic eq, input logic gt,
                                          input logic lt);
      logic take;
      if (op == 8'h01) return RAM | A | INC;
      if (op == 8'h02) return RAM | B | INC;
      take = (op == 8'h0A) || (op == 8'h0B && eq) || (op == 8'h0C && gt) || (op == 8'h0D && lt);
      return take ? (RAM | LD) : INC;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("ctrl", {22'b0, act}, {22'b0, exp_ctrl});
         check("operation", {24'b0, operation}, {24'b0, exp_op});
         check("step", {29'b0, step}, {29'b0, exp_step});
         check("halted", {31'b0, halted}, {31'b0, exp_halt});
         check("bus_excl",
               {31'b0, (32'(pc_enable_out) + 32'(ram_enable_out) + 32'(c_enable_out)) <= 32'd1},
               32'd1);
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
      bus     = 8'($urandom);
      equal   = 1'($urandom_range(0, 1));
      greater = 1'($urandom_range(0, 1));
      lesser  = 1'($urandom_range(0, 1));
   endtask

   task automatic expect_now(input logic [9:0] c, input logic [2:0] s);
      exp_ctrl = c;
      exp_step = s;
      exp_op   = m_ir;
      exp_halt = m_halt;
   endtask

   task automatic run_instr(input logic [7:0] op, input logic force_fl, input logic [2:0] fl);
      if (t0_done) t0_done = 1'b0;
      else begin
         next_cycle();
         expect_now(PCO | MAR, 3'd0);
      end
      next_cycle();
      bus = op;
      expect_now(RAM | INC, 3'd1);
      m_ir = op;
      if (op == 8'h0F) begin
         m_halt = 1'b1;
         next_cycle();
         expect_now('0, 3'd2);
         repeat (22) begin
            next_cycle();
            expect_now('0, 3'd5);
         end
         return;
      end
      next_cycle();
      expect_now(t2_ctrl(op), 3'd2);
      if (long_op(op)) begin
         next_cycle();
         if (force_fl) {equal, greater, lesser} = fl;
         expect_now(t3_ctrl(op, equal, greater, lesser), 3'd3);
      end
   endtask

   task automatic reset_now();
      reset  = 1'b0;
      m_ir   = 8'h00;
      m_halt = 1'b0;
      expect_now('0, 3'd0);
   endtask

   task automatic reset_release(input int unsigned hold);
      repeat (hold) begin
         next_cycle();
         expect_now('0, 3'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      expect_now(PCO | MAR, 3'd0);
      t0_done = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; bus = '0; equal = 1'b0; greater = 1'b0; lesser = 1'b0;
      m_ir = 8'h00; m_halt = 1'b0;
      expect_now('0, 3'd0);
      chk_en = 1'b1;

      check("pin_t2_add", {22'b0, t2_ctrl(8'h03)}, {22'b0, 10'h280});
      check("pin_t2_subo", {22'b0, t2_ctrl(8'h08)}, {22'b0, 10'h081});
      check("pin_t3_lda", {22'b0, t3_ctrl(8'h01, 1'b0, 1'b0, 1'b0)}, {22'b0, 10'h212});
      check("pin_t3_jeq_t", {22'b0, t3_ctrl(8'h0B, 1'b1, 1'b0, 1'b0)}, {22'b0, 10'h00A});
      check("pin_t3_jeq_n", {22'b0, t3_ctrl(8'h0B, 1'b0, 1'b1, 1'b1)}, {22'b0, 10'h010});
      check("pin_t2_unk", {22'b0, t2_ctrl(8'h7E)}, {22'b0, 10'h000});

      reset_release(2);

      run_instr(8'h03, 1'b0, 3'b000);
      run_instr(8'h01, 1'b0, 3'b000);
      run_instr(8'h09, 1'b0, 3'b000);
      run_instr(8'h0B, 1'b1, 3'b100);
      run_instr(8'h09, 1'b0, 3'b000);
      run_instr(8'h0B, 1'b1, 3'b011);
      run_instr(8'h0C, 1'b1, 3'b010);
      run_instr(8'h0D, 1'b1, 3'b101);
      run_instr(8'h0A, 1'b1, 3'b000);
      run_instr(8'h7E, 1'b0, 3'b000);

      // Reset in the middle of an ADD's T2.
      next_cycle();
      expect_now(PCO | MAR, 3'd0);
      next_cycle();
      bus = 8'h03;
      expect_now(RAM | INC, 3'd1);
      m_ir = 8'h03;
      next_cycle();
      expect_now(C | A, 3'd2);
      #1;
      check("t2_add_live", {22'b0, act}, {22'b0, C | A});
      #1;
      reset_now();
      #1;
      check("rst_ctrl", {22'b0, act}, 32'd0);
      check("rst_op", {24'b0, operation}, 32'h00);
      check("rst_step", {29'b0, step}, 32'd0);
      reset_release(3);

      for (int i = 0; i < 400; i++) begin
         int unsigned r;
         logic [7:0] op;
         r = $urandom_range(0, 19);
         op = (r < 15) ? 8'(r) : 8'($urandom_range(16, 255));
         run_instr(op, 1'b0, 3'b000);
      end

      run_instr(8'h0F, 1'b0, 3'b000);
      #2;
      reset_now();
      #1;
      check("halt_rst_halted", {31'b0, halted}, 32'd0);
      check("halt_rst_op", {24'b0, operation}, 32'h00);
      reset_release(1);
      run_instr(8'h02, 1'b0, 3'b000);
      run_instr(8'h05, 1'b0, 3'b000);

      @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction register plus microstep sequencer for the 8-bit computer; sits directly upstream of the ALU. It fetches each opcode off the shared bus, holds it on `operation`, and drives the per-cycle enables for the ALU (A/B load, result drive, flag latch), the program counter, the MAR/RAM and the output register. It consumes the ALU's latched `equal`/`greater`/`lesser` flags for conditional jumps.

## Interface
- No parameters; opcode and width constants come from the shared package.
- `clk`  input  1  system clock, rising-edge.
- `reset`  input  1  asynchronous, active-low reset.
- `bus`  input  8  shared data bus (opcode/operand source).
- `equal`, `greater`, `lesser`  input  1 each  latched ALU flags.
- `operation`  output  8  current instruction register contents, to ALU `operation`.
- `a_enable_in`, `b_enable_in`, `c_enable_out`, `flags_enable_in`  output  1 each  ALU controls.
- `pc_enable_out`, `pc_inc`, `pc_load`  output  1 each  program counter controls.
- `mar_enable_in`, `ram_enable_out`, `out_enable_in`  output  1 each  memory/output register controls.
- `step`  output  3  current microstep T0–T4.
- `halted`  output  1  high after HLT until reset.

## Operation
- Opcodes: 00 NOP, 01 LDA #imm, 02 LDB #imm, 03 ADD→A, 04 ADD→B, 05 ADD→OUT, 06 SUB→A, 07 SUB→B, 08 SUB→OUT, 09 CMP, 0A JMP #addr, 0B JEQ, 0C JGT, 0D JLT, 0F HLT; any other value executes as NOP.
- T0 (all): `pc_enable_out`, `mar_enable_in`.
- T1 (all): `ram_enable_out`, `pc_inc`; IR loads `bus` at end of T1.
- T2: LDA/LDB/JMP/Jcc → `pc_enable_out`, `mar_enable_in`. ADD/SUB → `c_enable_out` plus dest enable (`a_enable_in`/`b_enable_in`/`out_enable_in`). CMP → `flags_enable_in`. NOP/unknown → none, return to T0. HLT → set `halted`.
- T3: LDA/LDB → `ram_enable_out`, `a_enable_in`/`b_enable_in`, `pc_inc`. JMP, or Jcc with its flag high → `ram_enable_out`, `pc_load`. Jcc with flag low → `pc_inc` only (skip operand).
- Instruction lengths: NOP/ALU/CMP 3 cycles; LDx/JMP/Jcc 4 cycles; step returns to T0 after the last step.
- HLT: sequencer parks in HALT; all control outputs 0, `operation` holds 0F, `halted`=1; only reset exits.
- At most one bus driver asserted in any cycle (`pc_enable_out`, `ram_enable_out`, `c_enable_out` mutually exclusive).

## Timing
- State (`step`, IR, `halted`) registered on rising `clk`; control outputs are a Moore decode of `step` + IR, valid shortly after each edge, sampled by consumers on the next edge.
- `operation` stable from end of T1 through the whole execute phase, so ALU result mux selects correctly during T2.
- Jcc samples flags combinationally during T3; flags from a CMP in the immediately preceding instruction are visible (latched at end of its T2).
- Reset low (any time, mid-instruction included): `step`=0, `operation`=00, `halted`=0, every control output forced 0 while reset is low. First fetch T0 on the first rising edge after reset release.
- Reset during HALT clears `halted` same way.

## Structure
- Shared package `cpu_pkg`: opcode localparams, microstep encoding (T0–T4, HALT), control-word bit positions.
- One sub-module `control_decode`: purely combinational map (step, opcode, flags, halted) → control word. Top holds IR, step counter and halt flag.

## Test plan
- Reset low mid-T2 of ADD → all enables 0, `step`=0, `operation`=00; release → T0 asserts `pc_enable_out`+`mar_enable_in`.
- Bus 03 at T1 → `operation`=03 from next cycle; T2 asserts `c_enable_out`+`a_enable_in` only; next cycle `step`=0.
- LDA with bus 01 then 2A → T3 asserts `ram_enable_out`+`a_enable_in`+`pc_inc`; instruction spans exactly 4 cycles.
- CMP then JEQ with `equal`=1 → T3 `pc_load`=1, `pc_inc`=0; repeat with `equal`=0 → `pc_load`=0, `pc_inc`=1.
- Bus 0F → `halted`=1 from T2 onward, all controls 0 for 20+ cycles; reset clears.
- Bus 7E (unknown) → behaves as NOP, 3 cycles, no enables after T1; bus-driver exclusivity assertion holds throughout.
